// File: rtl/timer_pkg.sv
// Shared constants and types for the millisecond alarm timer.
// Register map: addr[3:2] selects channel, addr[1:0] selects register.
package timer_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] REG_CMP    = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_PER = 1;
  localparam int CTRL_ACK = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRED = 2'd2
  } state_e;

endpackage

// File: rtl/timer_chan.sv
// One alarm channel: deadline/period registers, control FSM,
// wrap-safe compare and pending/overrun tracking.
module timer_chan
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_now,
  input  logic        i_wr_cmp,
  input  logic        i_wr_per,
  input  logic        i_wr_ctrl,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_cmp,
  output logic [31:0] o_period,
  output logic [31:0] o_ctrl,
  output logic        o_pend
);

  logic [31:0] r_cmp;
  logic [31:0] r_period;
  logic        r_en;
  logic        r_per;
  logic        r_pend;
  logic        r_ovr;
  state_e      r_state;

  logic w_due;
  logic w_fire;
  logic w_reload;
  logic w_ack;

  // Signed difference keeps the compare correct across wrap of now.
  assign w_due    = $signed(i_now - r_cmp) >= 0;
  assign w_fire   = (r_state == ST_ARMED) && w_due;
  assign w_reload = r_per && (r_period != '0);
  assign w_ack    = i_wr_ctrl && i_wdata[CTRL_ACK];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmp    <= '0;
      r_period <= '0;
      r_en     <= 1'b0;
      r_per    <= 1'b0;
      r_pend   <= 1'b0;
      r_ovr    <= 1'b0;
      r_state  <= ST_IDLE;
    end else begin
      if (i_wr_cmp)
        r_cmp <= i_wdata;
      else if (w_fire && w_reload)
        r_cmp <= r_cmp + r_period;

      if (i_wr_per)
        r_period <= i_wdata;

      // A fire beats a coincident ack for pending; ack still wins on ovr.
      if (w_fire)
        r_pend <= 1'b1;
      else if (w_ack)
        r_pend <= 1'b0;

      if (w_ack)
        r_ovr <= 1'b0;
      else if (w_fire && r_pend)
        r_ovr <= 1'b1;

      if (i_wr_ctrl) begin
        r_per <= i_wdata[CTRL_PER];
        if (!i_wdata[CTRL_EN]) begin
          r_en    <= 1'b0;
          r_state <= ST_IDLE;
        end else if (r_state == ST_FIRED) begin
          if (w_ack)
            r_state <= ST_IDLE;
        end else if (r_state == ST_IDLE) begin
          r_en    <= 1'b1;
          r_state <= ST_ARMED;
        end else if (w_fire && !w_reload) begin
          r_en    <= 1'b0;
          r_state <= ST_FIRED;
        end else begin
          r_en <= 1'b1;
        end
      end else if (w_fire && !w_reload) begin
        r_en    <= 1'b0;
        r_state <= ST_FIRED;
      end
    end
  end

  assign o_cmp    = r_cmp;
  assign o_period = r_period;
  assign o_ctrl   = {26'b0, r_state, r_ovr, r_pend, r_per, r_en};
  assign o_pend   = r_pend;

endmodule

// File: rtl/timer_ctrl.sv
// Multi-channel alarm timer: register decode, read-back path
// and lowest-index interrupt priority encoder.
module timer_ctrl #(
  parameter int NUM_CH = timer_pkg::NUM_CH
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] now,
  input  logic        we,
  input  logic        re,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq,
  output logic [1:0]  irq_id
);

  import timer_pkg::*;

  logic [1:0]  w_ch;
  logic [1:0]  w_rs;
  logic [31:0] w_cmp    [NUM_CH];
  logic [31:0] w_period [NUM_CH];
  logic [31:0] w_ctrl   [NUM_CH];
  logic [NUM_CH-1:0] w_pend;
  logic [31:0] w_rmux;
  logic [1:0]  w_id;

  logic [31:0] r_rdata;
  logic        r_rvalid;
  logic        r_irq;
  logic [1:0]  r_irq_id;

  assign w_ch = addr[3:2];
  assign w_rs = addr[1:0];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic w_hit;
    assign w_hit = we && (w_ch == 2'(g));

    timer_chan u_chan (
      .clk       (clk),
      .rst       (rst),
      .i_now     (now),
      .i_wr_cmp  (w_hit && (w_rs == REG_CMP)),
      .i_wr_per  (w_hit && (w_rs == REG_PERIOD)),
      .i_wr_ctrl (w_hit && (w_rs == REG_CTRL)),
      .i_wdata   (wdata),
      .o_cmp     (w_cmp[g]),
      .o_period  (w_period[g]),
      .o_ctrl    (w_ctrl[g]),
      .o_pend    (w_pend[g])
    );
  end

  // Reads sample pre-edge contents, so a same-cycle write is not seen.
  always_comb begin
    w_rmux = '0;
    unique case (w_rs)
      REG_CMP:    w_rmux = w_cmp[w_ch];
      REG_PERIOD: w_rmux = w_period[w_ch];
      REG_CTRL:   w_rmux = w_ctrl[w_ch];
      default:    w_rmux = '0;
    endcase
  end

  always_comb begin
    w_id = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (w_pend[i])
        w_id = 2'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
      r_irq    <= 1'b0;
      r_irq_id <= '0;
    end else begin
      r_rvalid <= re;
      r_rdata  <= re ? w_rmux : '0;
      r_irq    <= |w_pend;
      r_irq_id <= w_id;
    end
  end

  assign rdata  = r_rdata;
  assign rvalid = r_rvalid;
  assign irq    = r_irq;
  assign irq_id = r_irq_id;

endmodule
